// File: rtl/sparse_pkg.sv
// Shared types and helpers for the 2:4 structured-sparsity datapath.
package sparse_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int IDX_WIDTH  = 2;
    localparam int GROUP_SIZE = 4;
    // One extra bit so |-128| = 128 is representable.
    localparam int MAG_WIDTH  = DATA_WIDTH + 1;
    localparam int NUM_PAIRS  = GROUP_SIZE * (GROUP_SIZE - 1) / 2;

    typedef logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] dense_weight_vec_t;
    typedef logic [GROUP_SIZE-1:0][MAG_WIDTH-1:0]  mag_vec_t;

    // Compressed 2-of-4 packet as consumed by the sparse MAC PE.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] val_0;
        logic [DATA_WIDTH-1:0] val_1;
        logic [IDX_WIDTH-1:0]  idx_0;
        logic [IDX_WIDTH-1:0]  idx_1;
    } sparse_packet_t;

    // Flat bit position of the comparison bit for pair (i, j), i < j.
    // Order: (0,1)(0,2)(0,3)(1,2)(1,3)(2,3).
    function automatic int pair_idx(input int i, input int j);
        return i * GROUP_SIZE - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Unsigned magnitude of a two's-complement weight.
    function automatic logic [MAG_WIDTH-1:0] abs_mag(input logic [DATA_WIDTH-1:0] w);
        logic [MAG_WIDTH-1:0] ext;
        ext = {w[DATA_WIDTH-1], w};
        return w[DATA_WIDTH-1] ? (~ext + MAG_WIDTH'(1)) : ext;
    endfunction

endpackage

// File: rtl/sparse_top2_select.sv
// Picks the two largest-magnitude entries of a group. Ties go to the lower
// index, so the result is a strict ranking and exactly two entries survive.
module sparse_top2_select
    import sparse_pkg::*;
(
    input  logic [GROUP_SIZE-1:0][MAG_WIDTH-1:0] mag_i,
    input  logic [NUM_PAIRS-1:0]                 gt_i,
    output logic [IDX_WIDTH-1:0]                 idx_0_o,
    output logic [IDX_WIDTH-1:0]                 idx_1_o,
    output logic [GROUP_SIZE-1:0]                keep_o
);

    // beat[i][j] set when element j outranks element i.
    logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0] beat;

    // For a < b, a wins on strictly greater or equal magnitude (lower index
    // breaks the tie); otherwise b wins. Each pair fills both directions.
    always_comb begin
        beat = '0;
        for (int a = 0; a < GROUP_SIZE; a++) begin
            for (int b = a + 1; b < GROUP_SIZE; b++) begin
                beat[b][a] =   gt_i[pair_idx(a, b)] || (mag_i[a] == mag_i[b]);
                beat[a][b] = !(gt_i[pair_idx(a, b)] || (mag_i[a] == mag_i[b]));
            end
        end
    end

    // An element survives when fewer than two others outrank it.
    always_comb begin
        keep_o = '0;
        for (int i = 0; i < GROUP_SIZE; i++)
            keep_o[i] = ($countones(beat[i]) < 2);
    end

    // Lowest kept index goes to slot 0, highest to slot 1.
    always_comb begin
        idx_0_o = '0;
        idx_1_o = '0;
        for (int i = GROUP_SIZE - 1; i >= 0; i--)
            if (keep_o[i]) idx_0_o = IDX_WIDTH'(i);
        for (int i = 0; i < GROUP_SIZE; i++)
            if (keep_o[i]) idx_1_o = IDX_WIDTH'(i);
    end

endmodule

// File: rtl/sparse_encoder_2to4.sv
// Streaming 2:4 compressor: dense groups of four signed weights in, the two
// largest-magnitude weights plus their indices out. Two elastic stages:
// S1 registers weights, magnitudes and pairwise compares; S2 selects and
// drives the outputs. Also keeps saturating pruning statistics.
module sparse_encoder_2to4
    import sparse_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  dense_weight_vec_t    in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output sparse_packet_t       out_pkt,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] grp_cnt,
    output logic [CNT_WIDTH-1:0] drop_nz_cnt
);

    localparam int DROP_W = $clog2(GROUP_SIZE + 1);

    // Stage enables; a stage may load when empty or when it is draining.
    logic adv1, adv2;

    // S1 state
    logic                                v1_q;
    dense_weight_vec_t                   w1_q;
    logic                                last1_q;
    logic [GROUP_SIZE-1:0][MAG_WIDTH-1:0] mag1_q, mag_d;
    logic [NUM_PAIRS-1:0]                gt1_q, gt_d;

    // S2 state
    logic           v2_q;
    sparse_packet_t pkt2_q, pkt_d;
    logic           last2_q;

    // Selection results and pruning count for the group sitting in S1
    logic [IDX_WIDTH-1:0]  sel_idx0, sel_idx1;
    logic [GROUP_SIZE-1:0] sel_keep;
    logic [DROP_W-1:0]     drop_n;

    // Statistics
    logic [CNT_WIDTH-1:0] grp_q, grp_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CNT_WIDTH:0]   drop_sum;
    logic                 out_xfer;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;
    assign out_xfer = v2_q && out_ready;

    // Magnitudes and all pairwise compares for the incoming group.
    always_comb begin
        mag_d = '0;
        gt_d  = '0;
        for (int i = 0; i < GROUP_SIZE; i++)
            mag_d[i] = abs_mag(in_data[i]);
        for (int a = 0; a < GROUP_SIZE; a++)
            for (int b = a + 1; b < GROUP_SIZE; b++)
                gt_d[pair_idx(a, b)] = (mag_d[a] > mag_d[b]);
    end

    // S1: capture the group when the stage advances and input is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            w1_q    <= '0;
            last1_q <= 1'b0;
            mag1_q  <= '0;
            gt1_q   <= '0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                w1_q    <= in_data;
                last1_q <= in_last;
                mag1_q  <= mag_d;
                gt1_q   <= gt_d;
            end
        end
    end

    sparse_top2_select u_sel (
        .mag_i   (mag1_q),
        .gt_i    (gt1_q),
        .idx_0_o (sel_idx0),
        .idx_1_o (sel_idx1),
        .keep_o  (sel_keep)
    );

    // Build the packet and count nonzero weights among the pruned ones.
    always_comb begin
        pkt_d       = '0;
        pkt_d.val_0 = w1_q[sel_idx0];
        pkt_d.val_1 = w1_q[sel_idx1];
        pkt_d.idx_0 = sel_idx0;
        pkt_d.idx_1 = sel_idx1;
        drop_n      = '0;
        for (int i = 0; i < GROUP_SIZE; i++)
            if (!sel_keep[i] && (w1_q[i] != '0))
                drop_n = drop_n + DROP_W'(1);
    end

    // S2: output register; holds its packet while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            pkt2_q  <= '0;
            last2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                pkt2_q  <= pkt_d;
                last2_q <= last1_q;
            end
        end
    end

    // Next-state of the statistics: clear beats any same-cycle increment,
    // and both counters stick at all-ones.
    always_comb begin
        grp_d    = grp_q;
        drop_d   = drop_q;
        drop_sum = {1'b0, drop_q} + (CNT_WIDTH + 1)'(drop_n);
        if (clear) begin
            grp_d  = '0;
            drop_d = '0;
        end else begin
            if (out_xfer && (grp_q != '1))
                grp_d = grp_q + CNT_WIDTH'(1);
            if (adv2 && v1_q)
                drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q  <= '0;
            drop_q <= '0;
        end else begin
            grp_q  <= grp_d;
            drop_q <= drop_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_pkt     = pkt2_q;
    assign out_last    = last2_q;
    assign grp_cnt     = grp_q;
    assign drop_nz_cnt = drop_q;

endmodule

// File: tb/tb_sparse_encoder_2to4.sv
// Scoreboard bench for the 2:4 compressor and its selection sub-module.
module tb_sparse_encoder_2to4;
    import sparse_pkg::*;

    localparam int CW  = 16;
    localparam int SAT = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b1;
    dense_weight_vec_t in_data = '0;
    logic              in_ready, out_valid, out_last;
    sparse_packet_t    out_pkt;
    logic [CW-1:0]     grp_cnt, drop_nz_cnt;

    // Standalone selection unit
    logic [GROUP_SIZE-1:0][MAG_WIDTH-1:0] s_mag;
    logic [NUM_PAIRS-1:0]                 s_gt;
    logic [IDX_WIDTH-1:0]                 s_i0, s_i1;
    logic [GROUP_SIZE-1:0]                s_keep;

    sparse_encoder_2to4 #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .out_last(out_last),
        .grp_cnt(grp_cnt), .drop_nz_cnt(drop_nz_cnt)
    );

    sparse_top2_select u_sel (
        .mag_i(s_mag), .gt_i(s_gt), .idx_0_o(s_i0), .idx_1_o(s_i1), .keep_o(s_keep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        sparse_packet_t pkt;
        logic           last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0, n_err = 0;
    int   exp_grp = 0, exp_drop = 0;
    bit   rnd_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mag(input logic [7:0] w);
        return w[7] ? 256 - int'(w) : int'(w);
    endfunction

    function automatic dense_weight_vec_t mkw(input int a, input int b, input int c, input int d);
        dense_weight_vec_t r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    function automatic sparse_packet_t mkp(input int v0, input int v1, input int i0, input int i1);
        sparse_packet_t p;
        p.val_0 = 8'(v0); p.val_1 = 8'(v1); p.idx_0 = 2'(i0); p.idx_1 = 2'(i1);
        return p;
    endfunction

    // Reference: take the strict maximum (first wins on ties), then the
    // strict maximum of the rest, then order the two by index.
    task automatic model(input dense_weight_vec_t w, output sparse_packet_t p, output int d);
        int b, s, lo, hi;
        b = 0;
        for (int i = 1; i < 4; i++) if (mag(w[i]) > mag(w[b])) b = i;
        s = -1;
        for (int i = 0; i < 4; i++)
            if (i != b) begin
                if (s < 0) s = i;
                else if (mag(w[i]) > mag(w[s])) s = i;
            end
        lo = (b < s) ? b : s;
        hi = (b < s) ? s : b;
        d = 0;
        for (int i = 0; i < 4; i++) if (i != lo && i != hi && w[i] != 8'd0) d++;
        p = mkp(int'(w[lo]), int'(w[hi]), lo, hi);
    endtask

    task automatic drive(input dense_weight_vec_t w, input logic last,
                         input sparse_packet_t xp, input int xd);
        bit acc;
        int guard;
        sb.push_back('{pkt: xp, last: last});
        if (exp_grp < SAT) exp_grp++;
        exp_drop = (exp_drop + xd > SAT) ? SAT : exp_drop + xd;
        in_valid = 1'b1; in_data = w; in_last = last;
        acc = 1'b0; guard = 0;
        while (!acc) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 50) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input dense_weight_vec_t w, input logic last);
        sparse_packet_t p;
        int d;
        model(w, p, d);
        drive(w, last, p, d);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 60) begin @(posedge clk); g++; end
        @(posedge clk); #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_grp"},  64'(grp_cnt),     64'(exp_grp));
        chk({tag, "_drop"}, 64'(drop_nz_cnt), 64'(exp_drop));
    endtask

    function automatic dense_weight_vec_t rnd_w();
        dense_weight_vec_t r;
        for (int i = 0; i < 4; i++)
            r[i] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 6)) - 3);
        return r;
    endfunction

    // Scoreboard consumer: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_extra", 64'(out_valid), 64'd0);
            else begin
                mon_e = sb.pop_front();
                chk("pkt",  64'(out_pkt),  64'(mon_e.pkt));
                chk("last", 64'(out_last), 64'(mon_e.last));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        dense_weight_vec_t w;
        sparse_packet_t    p;
        int                d;

        // Selection unit on its own
        for (int t = 0; t < 30; t++) begin
            w = rnd_w();
            for (int i = 0; i < 4; i++) s_mag[i] = 9'(mag(w[i]));
            for (int a = 0; a < 4; a++)
                for (int b = a + 1; b < 4; b++)
                    s_gt[pair_idx(a, b)] = (mag(w[a]) > mag(w[b]));
            #1;
            model(w, p, d);
            chk("sel_i0",   64'(s_i0),   64'(p.idx_0));
            chk("sel_i1",   64'(s_i1),   64'(p.idx_1));
            chk("sel_keep", 64'(s_keep), 64'((4'b1 << p.idx_0) | (4'b1 << p.idx_1)));
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_out_pkt",   64'(out_pkt),     64'd0);
        chk("rst_out_last",  64'(out_last),    64'd0);
        chk("rst_grp",       64'(grp_cnt),     64'd0);
        chk("rst_drop",      64'(drop_nz_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic encode with latency check
        drive(mkw(10, -50, 3, 20), 1'b0, mkp(-50, 20, 1, 3), 2);
        chk("lat_s1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_s2", 64'(out_valid), 64'd1);
        drain();
        chk_cnt("basic");

        // All-zero group and a single nonzero
        drive(mkw(0, 0, 0, 0), 1'b0, mkp(0, 0, 0, 1), 0);
        drive(mkw(0, 0, 7, 0), 1'b0, mkp(0, 7, 0, 2), 0);
        drain();
        chk_cnt("zero");

        // Ties and extremes
        drive(mkw(5, -5, 5, 5),      1'b0, mkp(5, -5, 0, 1),     2);
        drive(mkw(127, -128, 0, 1), 1'b0, mkp(127, -128, 0, 1), 1);
        drain();
        chk_cnt("tie");

        // Backpressure: stall downstream for four edges mid-burst
        fork
            begin
                for (int k = 0; k < 6; k++) send(rnd_w(), k == 5);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk_cnt("bp");

        // Random traffic with random downstream stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 150; k++) send(rnd_w(), ($urandom % 8) == 0);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom % 3) != 0;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk_cnt("rand");

        // Saturation of both counters
        for (int k = 0; k < (1 << 16) + 3; k++)
            drive(mkw(1, 1, 1, 1), 1'b0, mkp(1, 1, 0, 1), 2);
        drain();
        chk_cnt("sat");

        // Clear coinciding with an accept, an S2 load and an output transfer
        drive(mkw(1, 1, 1, 1), 1'b0, mkp(1, 1, 0, 1), 2);
        drive(mkw(2, 2, 2, 2), 1'b0, mkp(2, 2, 0, 1), 2);
        clear = 1'b1;
        drive(mkw(3, 3, 3, 3), 1'b1, mkp(3, 3, 0, 1), 2);
        clear = 1'b0;
        chk("clr_grp",  64'(grp_cnt),     64'd0);
        chk("clr_drop", 64'(drop_nz_cnt), 64'd0);
        exp_grp = 2; exp_drop = 2;
        drain();
        chk_cnt("post_clr");

        // Reset with two groups in flight
        send(rnd_w(), 1'b0);
        send(rnd_w(), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        sb.delete();
        exp_grp = 0; exp_drop = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", 64'(in_ready),  64'd1);
        chk("rst_mid_ov",    64'(out_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk_cnt("rst_mid");
        drive(mkw(10, -50, 3, 20), 1'b1, mkp(-50, 20, 1, 3), 2);
        drain();
        chk_cnt("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sparse_encoder_2to4.md
Name: sparse_encoder_2to4

Overview:
- Streaming 2:4 structured-sparsity compressor.
- Accepts dense groups of 4 signed weights, keeps the 2 largest-magnitude entries, and emits a sparse_pkg::sparse_packet_t (val_0, val_1, idx_0, idx_1).
- This packet is exactly what the sparse MAC processing element consumes.
- Sits between the weight loader/DMA and the PE weight buffer; also keeps pruning statistics for software.

Parameters:
- CNT_WIDTH, 16, width of the saturating statistics counters.
- DATA_WIDTH, IDX_WIDTH and GROUP_SIZE come from sparse_pkg (8, 2, 4); they are not module parameters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of statistics counters; pipeline unaffected
- in_valid  in  1  dense group valid
- in_ready  out  1  encoder can accept a group
- in_data  in  sparse_pkg::dense_weight_vec_t  4 x signed 8-bit weights; element i at index i
- in_last  in  1  last group of a weight tile
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts packet
- out_pkt  out  sparse_pkg::sparse_packet_t  compressed packet
- out_last  out  1  in_last delayed with its group
- grp_cnt  out  CNT_WIDTH  packets accepted downstream, saturating
- drop_nz_cnt  out  CNT_WIDTH  nonzero weights pruned, saturating

Behaviour:
- Reset values: out_valid=0, out_pkt=0, out_last=0, grp_cnt=0, drop_nz_cnt=0, all stage valids=0. in_ready=1 after reset.
- Handshake: a transfer occurs when valid && ready on the same edge. out_pkt and out_last hold stable while out_valid=1 && out_ready=0.
- Pipeline is 2 registered stages, S1 and S2 (S2 drives the outputs). Latency is 2 cycles from input accept to out_valid.
- Throughput is 1 group/clk while out_ready=1.
- Stage enables:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1, which is combinational from out_ready.
- When out_ready=0 with both stages full, in_ready=0 and no data is lost or duplicated.
- S1 registers:
  - the 4 weights and in_last;
  - 9-bit unsigned magnitudes m_i = |w_i|, so -128 gives 128;
  - the 6 pairwise comparison bits gt_ij = (m_i > m_j).
- S2 selection rule:
  - Element j beats i when m_j > m_i, or when m_j == m_i and j < i.
  - Element i is kept if fewer than 2 elements beat it. Exactly 2 elements are always kept.
- Output ordering: idx_0 < idx_1 always; val_0 = w[idx_0], val_1 = w[idx_1]. Values are passed unmodified (signed).
- All-zero group: idx_0=0, idx_1=1, vals 0.
- Statistics, updated on the S2 load edge (adv2 && v1):
  - drop_nz_cnt += number of nonzero weights among the 2 pruned.
  - grp_cnt += 1 on each output transfer (out_valid && out_ready).
  - Both counters saturate at all-ones.
- clear: counters go to 0 on the next edge and take priority over a same-cycle increment. In-flight data is not affected.
- Reset mid-stream: in-flight groups are discarded and out_valid drops asynchronously. No partial packet is emitted after release.

Decomposition:
- sparse_pkg additions:
  - dense_weight_vec_t: packed array [GROUP_SIZE-1:0] of logic [DATA_WIDTH-1:0].
  - MAG_WIDTH = DATA_WIDTH+1.
- sparse_pkg existing items reused: sparse_packet_t, DATA_WIDTH, IDX_WIDTH, GROUP_SIZE.
- One sub-module, sparse_top2_select: combinational; inputs are the magnitudes and the gt bits; outputs are idx_0, idx_1 and a 4-bit keep mask. It is instantiated in S2 and unit-tested on its own.

Test Plan:
- in_data={w0=10,w1=-50,w2=3,w3=20}, out_ready=1 -> after 2 clk: out_valid=1, idx_0=1 val_0=-50, idx_1=3 val_1=20; drop_nz_cnt=2, grp_cnt=1.
- All-zero group, then {0,0,7,0} -> first packet idx 0/1 vals 0/0, drop +0; second packet idx_0=0 val_0=0, idx_1=2 val_1=7, drop +0.
- Ties and extremes:
  - {5,-5,5,5} -> idx 0/1 vals 5/-5, drop_nz +2.
  - {127,-128,0,1} -> idx 0/1 vals 127/-128, drop_nz +1.
- Backpressure: 6 back-to-back groups with in_last on the 6th; out_ready held 0 for cycles 3-6 -> in_ready=0 once both stages are full. All 6 packets emerge in order, unchanged while stalled; out_last is set only on the 6th; grp_cnt=6.
- Saturation/clear:
  - Force 2^16+3 groups of {1,1,1,1} -> drop_nz_cnt and grp_cnt stick at 0xFFFF.
  - Pulse clear coincident with an accept -> both counters read 0.
- Assert rst_n=0 with 2 groups in flight -> out_valid=0 immediately. After release, in_ready=1, no stale packet is emitted, and the next group encodes correctly.
